// File: rtl/rv_multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle RV32I control FSM and its datapath/memories.
interface rv_multicycle_ctrl_if;
  logic [31:0] i_inst;
  logic        i_imemAck;
  logic        i_dmemAck;
  logic        i_brTaken;
  logic        o_imemReq;
  logic        o_irWe;
  logic        o_dmemReq;
  logic        o_dmemWe;
  logic [2:0]  o_immType;
  logic        o_aluSrcA;
  logic        o_aluSrcB;
  logic [1:0]  o_wbSel;
  logic        o_regWe;
  logic        o_pcWe;
  logic [1:0]  o_pcSel;
  logic        o_retire;
  logic        o_trap;
  logic [1:0]  o_trapCause;

  modport master (
    input  i_inst, i_imemAck, i_dmemAck, i_brTaken,
    output o_imemReq, o_irWe, o_dmemReq, o_dmemWe, o_immType, o_aluSrcA, o_aluSrcB,
           o_wbSel, o_regWe, o_pcWe, o_pcSel, o_retire, o_trap, o_trapCause
  );

  modport slave (
    output i_inst, i_imemAck, i_dmemAck, i_brTaken,
    input  o_imemReq, o_irWe, o_dmemReq, o_dmemWe, o_immType, o_aluSrcA, o_aluSrcB,
           o_wbSel, o_regWe, o_pcWe, o_pcSel, o_retire, o_trap, o_trapCause
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath selects, memory handshakes and trap reporting (illegal opcode, memory timeout).
module rv_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  rv_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_LUI     = 4'd0,
    C_AUIPC   = 4'd1,
    C_JAL     = 4'd2,
    C_JALR    = 4'd3,
    C_BRANCH  = 4'd4,
    C_LOAD    = 4'd5,
    C_STORE   = 4'd6,
    C_OPIMM   = 4'd7,
    C_OP      = 4'd8,
    C_FENCE   = 4'd9,
    C_ILLEGAL = 4'd10
  } cls_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 32'd1);

  function automatic cls_e decode_class(input logic [6:0] opc);
    cls_e c;
    case (opc)
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b1100011: c = C_BRANCH;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b0010011: c = C_OPIMM;
      7'b0110011: c = C_OP;
      7'b0001111: c = C_FENCE;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_type_of(input cls_e c);
    logic [2:0] t;
    case (c)
      C_LUI, C_AUIPC: t = 3'd3;
      C_JAL:          t = 3'd4;
      C_BRANCH:       t = 3'd2;
      C_STORE:        t = 3'd1;
      default:        t = 3'd0;
    endcase
    return t;
  endfunction

  state_e          state_q, state_d;
  cls_e            cls_q, cls_d, dec_cls;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      imm_q, imm_d;
  logic [1:0]      cause_q, cause_d;

  logic       imem_req, ir_we, dmem_req, dmem_we, src_a, src_b;
  logic       reg_we, pc_we, retire, trap;
  logic [1:0] wb_sel, pc_sel;

  assign dec_cls = decode_class(bus.i_inst[6:0]);

  // State, timeout counter, opcode class, immediate type and trap cause registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_FETCH;
      cls_q   <= C_OP;
      cnt_q   <= '0;
      imm_q   <= 3'd0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      imm_q   <= imm_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and control decode; outputs are forced low while reset is held so a
  // pending memory request drops immediately. The counter is zero unless a wait continues.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    cnt_d    = '0;
    imm_d    = imm_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    src_a    = 1'b0;
    src_b    = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    trap     = 1'b0;
    wb_sel   = 2'd0;
    pc_sel   = 2'd0;
    if (i_rstn) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (bus.i_imemAck) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_HALT;
            cause_d = 2'd2;
          end else begin
            cnt_d = cnt_q + TO_W'(1'b1);
          end
        end
        S_DECODE: begin
          cls_d = dec_cls;
          imm_d = imm_type_of(dec_cls);
          case (dec_cls)
            C_ILLEGAL: begin
              state_d = S_HALT;
              cause_d = 2'd1;
            end
            C_FENCE: begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            C_OPIMM, C_LOAD, C_STORE, C_JALR: src_b = 1'b1;
            C_AUIPC: begin
              src_a = 1'b1;
              src_b = 1'b1;
            end
            default: src_b = 1'b0;
          endcase
          case (cls_q)
            C_BRANCH: begin
              pc_we   = 1'b1;
              pc_sel  = bus.i_brTaken ? 2'd1 : 2'd0;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            C_LOAD, C_STORE: state_d = S_MEM;
            default:         state_d = S_WB;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
          if (bus.i_dmemAck) begin
            if (cls_q == C_STORE) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d = S_HALT;
            cause_d = 2'd3;
          end else begin
            cnt_d = cnt_q + TO_W'(1'b1);
          end
        end
        S_WB: begin
          reg_we  = (bus.i_inst[11:7] != 5'd0);
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
          case (cls_q)
            C_LOAD: wb_sel = 2'd1;
            C_JAL: begin
              wb_sel = 2'd2;
              pc_sel = 2'd1;
            end
            C_JALR: begin
              wb_sel = 2'd2;
              pc_sel = 2'd2;
            end
            C_LUI:   wb_sel = 2'd3;
            default: wb_sel = 2'd0;
          endcase
        end
        S_HALT:  trap = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end else begin
      state_d = S_FETCH;
    end
  end

  assign bus.o_imemReq   = imem_req;
  assign bus.o_irWe      = ir_we;
  assign bus.o_dmemReq   = dmem_req;
  assign bus.o_dmemWe    = dmem_we;
  assign bus.o_immType   = imm_q;
  assign bus.o_aluSrcA   = src_a;
  assign bus.o_aluSrcB   = src_b;
  assign bus.o_wbSel     = wb_sel;
  assign bus.o_regWe     = reg_we;
  assign bus.o_pcWe      = pc_we;
  assign bus.o_pcSel     = pc_sel;
  assign bus.o_retire    = retire;
  assign bus.o_trap      = trap;
  assign bus.o_trapCause = cause_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: a driver plays instructions with chosen ack timing and
// queues the outcome predicted from the instruction rules; a monitor checks each retire/trap.
module tb_rv_multicycle_ctrl;
  localparam int TO = 4;
  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LOAD = 5;
  localparam int K_STORE = 6, K_OPIMM = 7, K_OP = 8, K_FENCE = 9, K_ILL = 10;

  typedef struct {
    int trap;
    int cause;
    int lat;
    int n_imem;
    int n_ir;
    int n_dmem;
    int n_dwe;
    int n_regwe;
    int has_exec;
    int srca;
    int srcb;
    int imm;
    int wbsel;
    int pcsel;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if bus();
  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] opc_of(input int k);
    case (k)
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_BR:    return 7'b1100011;
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_OPIMM: return 7'b0010011;
      K_OP:    return 7'b0110011;
      K_FENCE: return 7'b0001111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference outcome of one instruction, from the per-class cycle counts and control table.
  function automatic exp_t model(input int k, input int w, input int dw, input int br, input int rd);
    exp_t e;
    int   f;
    e = '{default: 0};
    if (w >= TO) begin
      e.trap = 1; e.cause = 2; e.lat = TO + 1; e.n_imem = TO;
      return e;
    end
    e.n_imem = w + 1;
    e.n_ir   = 1;
    f        = w + 1;
    e.pcsel  = 0;
    if (k == K_ILL) begin
      e.trap = 1; e.cause = 1; e.lat = f + 2;
      return e;
    end
    if (k == K_FENCE) begin
      e.lat = f + 1;
      return e;
    end
    e.has_exec = 1;
    e.imm  = (k == K_LUI || k == K_AUIPC) ? 3 : (k == K_JAL) ? 4 : (k == K_BR) ? 2 : (k == K_STORE) ? 1 : 0;
    e.srca = (k == K_AUIPC) ? 1 : 0;
    e.srcb = (k == K_OPIMM || k == K_LOAD || k == K_STORE || k == K_JALR || k == K_AUIPC) ? 1 : 0;
    if (k == K_BR) begin
      e.lat = f + 2; e.pcsel = br;
      return e;
    end
    if (k == K_LOAD || k == K_STORE) begin
      e.n_dmem = (dw < TO) ? dw + 1 : TO;
      e.n_dwe  = (k == K_STORE) ? e.n_dmem : 0;
      if (dw >= TO) begin
        e.trap = 1; e.cause = 3; e.lat = f + 2 + TO + 1;
        return e;
      end
      e.lat = f + 3 + dw;
      if (k == K_STORE) return e;
      e.lat = e.lat + 1;
    end else begin
      e.lat = f + 3;
    end
    e.n_regwe = (rd != 0) ? 1 : 0;
    e.wbsel   = (k == K_LOAD) ? 1 : (k == K_JAL || k == K_JALR) ? 2 : (k == K_LUI) ? 3 : 0;
    e.pcsel   = (k == K_JAL) ? 1 : (k == K_JALR) ? 2 : 0;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic ia, input logic da);
    bus.i_imemAck = ia;
    bus.i_dmemAck = da;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_imemAck = 1'b0;
    bus.i_dmemAck = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic halt_and_reset();
    repeat (3) cyc(rbit(), rbit());
    do_reset();
  endtask

  task automatic run_txn(input logic [31:0] inst, input int k, input int w, input int dw,
                         input logic br, input bit abort);
    bus.i_inst    = inst;
    bus.i_brTaken = br;
    if (!abort) sb.push_back(model(k, w, dw, int'(br), int'(inst[11:7])));
    for (int i = 0; i < w && i < TO; i++) cyc(1'b0, rbit());
    if (w >= TO) begin halt_and_reset(); return; end
    cyc(1'b1, rbit());
    cyc(rbit(), rbit());
    if (k == K_ILL) begin halt_and_reset(); return; end
    if (k == K_FENCE) return;
    cyc(rbit(), rbit());
    if (k == K_BR) return;
    if (k == K_LOAD || k == K_STORE) begin
      if (abort) begin
        bus.i_imemAck = 1'b0;
        bus.i_dmemAck = 1'b0;
        #2;
        chk("abort_req_before", int'(bus.o_dmemReq), 1);
        rstn = 1'b0;
        #1;
        chk("abort_req_drop", int'(bus.o_dmemReq), 0);
        chk("abort_we_drop", int'(bus.o_dmemWe), 0);
        chk("abort_no_retire", int'(bus.o_retire), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        return;
      end
      for (int i = 0; i < dw && i < TO; i++) cyc(rbit(), 1'b0);
      if (dw >= TO) begin halt_and_reset(); return; end
      cyc(rbit(), 1'b1);
      if (k == K_STORE) return;
    end
    cyc(rbit(), rbit());
  endtask

  function automatic int quiet_bits();
    return int'({bus.o_imemReq, bus.o_irWe, bus.o_dmemReq, bus.o_dmemWe,
                 bus.o_regWe, bus.o_pcWe, bus.o_retire});
  endfunction

  // Monitor: accumulates per-instruction activity and checks it on every retire or trap.
  initial begin : monitor
    int   m_cyc, m_ir, n_imem, n_ir, n_dmem, n_dwe, n_regwe, x_a, x_b, x_imm;
    bit   halted;
    int   halt_cause;
    exp_t e;
    m_cyc = 0; m_ir = -100; n_imem = 0; n_ir = 0; n_dmem = 0; n_dwe = 0; n_regwe = 0;
    x_a = 0; x_b = 0; x_imm = 0; halted = 1'b0; halt_cause = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_cyc = 0; m_ir = -100; n_imem = 0; n_ir = 0; n_dmem = 0; n_dwe = 0; n_regwe = 0;
        halted = 1'b0;
      end else if (halted) begin
        chk("halt_quiet", quiet_bits(), 0);
        chk("halt_trap", int'(bus.o_trap), 1);
        chk("halt_cause", int'(bus.o_trapCause), halt_cause);
      end else begin
        m_cyc++;
        n_imem  += int'(bus.o_imemReq);
        n_ir    += int'(bus.o_irWe);
        n_dmem  += int'(bus.o_dmemReq);
        n_dwe   += int'(bus.o_dmemWe);
        n_regwe += int'(bus.o_regWe);
        if (bus.o_irWe) m_ir = m_cyc;
        if (m_cyc == m_ir + 2) begin
          x_a = int'(bus.o_aluSrcA); x_b = int'(bus.o_aluSrcB); x_imm = int'(bus.o_immType);
        end
        if (bus.o_retire || bus.o_trap) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("event_kind_trap", int'(bus.o_trap), e.trap);
            chk("latency", m_cyc, e.lat);
            chk("imem_req_cycles", n_imem, e.n_imem);
            chk("ir_we_count", n_ir, e.n_ir);
            chk("dmem_req_cycles", n_dmem, e.n_dmem);
            chk("dmem_we_cycles", n_dwe, e.n_dwe);
            chk("reg_we_count", n_regwe, e.n_regwe);
            if (e.has_exec != 0) begin
              chk("exec_srcA", x_a, e.srca);
              chk("exec_srcB", x_b, e.srcb);
              chk("imm_type", x_imm, e.imm);
            end
            if (e.trap != 0) begin
              chk("trap_cause", int'(bus.o_trapCause), e.cause);
              chk("trap_quiet", quiet_bits(), 0);
              halted     = 1'b1;
              halt_cause = e.cause;
            end else begin
              chk("pc_we", int'(bus.o_pcWe), 1);
              chk("pc_sel", int'(bus.o_pcSel), e.pcsel);
              chk("wb_sel", int'(bus.o_wbSel), e.wbsel);
              chk("no_trap", int'(bus.o_trap), 0);
            end
          end
          m_cyc = 0; m_ir = -100; n_imem = 0; n_ir = 0; n_dmem = 0; n_dwe = 0; n_regwe = 0;
        end
      end
    end
  end

  // Driver: reset checks, directed scenarios, then randomized instruction stream.
  initial begin : driver
    logic [31:0] r;
    logic [6:0]  opc;
    logic [4:0]  rd;
    int          k, w, dw;
    bus.i_inst    = 32'h0000_0000;
    bus.i_imemAck = 1'b0;
    bus.i_dmemAck = 1'b0;
    bus.i_brTaken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imemReq", int'(bus.o_imemReq), 0);
    chk("rst_irWe", int'(bus.o_irWe), 0);
    chk("rst_dmemReq", int'(bus.o_dmemReq), 0);
    chk("rst_regWe", int'(bus.o_regWe), 0);
    chk("rst_pcWe", int'(bus.o_pcWe), 0);
    chk("rst_retire", int'(bus.o_retire), 0);
    chk("rst_immType", int'(bus.o_immType), 0);
    chk("rst_wbSel", int'(bus.o_wbSel), 0);
    chk("rst_pcSel", int'(bus.o_pcSel), 0);
    chk("rst_trap", int'(bus.o_trap), 0);
    chk("rst_cause", int'(bus.o_trapCause), 0);
    rstn = 1'b1;

    run_txn(32'h0050_0093, K_OPIMM, 2, 0, 1'b0, 1'b0);
    run_txn(32'h0040_A103, K_LOAD,  0, 3, 1'b0, 1'b0);
    run_txn(32'h0000_0463, K_BR,    1, 0, 1'b1, 1'b0);
    run_txn(32'h0000_0463, K_BR,    0, 0, 1'b0, 1'b0);
    run_txn(32'hFFFF_FFFF, K_ILL,   0, 0, 1'b0, 1'b0);
    run_txn(32'h0050_0093, K_OPIMM, 6, 0, 1'b0, 1'b0);
    run_txn(32'h0050_0093, K_OPIMM, 3, 0, 1'b0, 1'b0);
    run_txn(32'h0020_A223, K_STORE, 0, 2, 1'b0, 1'b1);
    run_txn(32'h0020_8033, K_OP,    0, 0, 1'b0, 1'b0);
    run_txn(32'h0000_000F, K_FENCE, 1, 0, 1'b0, 1'b0);
    run_txn(32'h0040_A223, K_STORE, 0, 5, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      k  = $urandom_range(0, 10);
      r  = $urandom();
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      w  = ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
      dw = ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
      opc = opc_of(k);
      if (k == K_ILL) begin
        for (int t = 0; t < 50; t++) begin
          opc = 7'($urandom_range(0, 127));
          if (opc != 7'b0110111 && opc != 7'b0010111 && opc != 7'b1101111 && opc != 7'b1100111 &&
              opc != 7'b1100011 && opc != 7'b0000011 && opc != 7'b0100011 && opc != 7'b0010011 &&
              opc != 7'b0110011 && opc != 7'b0001111) break;
          opc = 7'b1111111;
        end
      end
      run_txn({r[31:12], rd, opc}, k, w, dw, rbit(), 1'b0);
    end

    repeat (3) cyc(1'b0, 1'b0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences instruction fetch, decode, execute, memory and writeback over the shared datapath: PC, IR, register file, ALU, immediate generator.
- Drives the immediate-type select, datapath mux selects, write enables and the memory request handshakes.
- Reports traps: illegal opcode, memory timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a memory request may wait for ack before trapping (1..65535).
- TO_W, 16: width of the internal timeout counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_inst  in  32  current IR contents (valid from DECODE onward).
- i_imemAck  in  1  instruction memory ack: data valid on the IR input this cycle.
- i_dmemAck  in  1  data memory ack.
- i_brTaken  in  1  branch compare result from ALU, valid in EXEC.
- o_imemReq  out  1  instruction fetch request.
- o_irWe  out  1  IR load enable.
- o_dmemReq  out  1  data memory request.
- o_dmemWe  out  1  data memory write (store).
- o_immType  out  3  immediate select: I=0, S=1, B=2, U=3, J=4.
- o_aluSrcA  out  1  0=rs1, 1=PC.
- o_aluSrcB  out  1  0=rs2, 1=immediate.
- o_wbSel  out  2  0=ALU, 1=load data, 2=PC+4, 3=immediate.
- o_regWe  out  1  register file write enable.
- o_pcWe  out  1  PC update enable.
- o_pcSel  out  2  0=PC+4, 1=PC+imm, 2=ALU result & ~1.
- o_retire  out  1  one-cycle pulse per completed instruction.
- o_trap  out  1  sticky trap flag.
- o_trapCause  out  2  0=none, 1=illegal, 2=imem timeout, 3=dmem timeout.

Behaviour:
- Reset (async, i_rstn=0): state=FETCH, all enables/requests 0, o_immType=0, selects 0, o_trap=0, o_trapCause=0, timeout counter 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs decode from registered state plus latched opcode class. Only the timeout counter, o_immType and the class register are datapath-like registers.
- FETCH: o_imemReq=1 until i_imemAck. On ack: o_irWe=1 that cycle, go to DECODE. Counter increments each waiting cycle; reaching TIMEOUT_CYCLES without ack -> HALT, cause 2.
- DECODE (1 cycle): latch opcode class and register o_immType from i_inst[6:0].
  - Opcode map: LUI 0110111 U; AUIPC 0010111 U; JAL 1101111 J; JALR 1100111 I; BRANCH 1100011 B; LOAD 0000011 I; STORE 0100011 S; OP-IMM 0010011 I; OP 0110011 (immType I, unused); FENCE 0001111 = NOP.
  - Any other opcode -> HALT, cause 1.
  - FENCE -> FETCH with o_pcWe=1, pcSel=0, o_retire=1.
- EXEC (1 cycle):
  - OP: srcA=0, srcB=0.
  - OP-IMM/LOAD/STORE/JALR: srcB=1.
  - AUIPC: srcA=1, srcB=1.
  - BRANCH: o_pcWe=1, pcSel = i_brTaken ? 1 : 0, o_retire=1, -> FETCH.
  - LOAD/STORE -> MEM; all others -> WB.
- MEM: o_dmemReq=1 (o_dmemWe=1 for STORE) held until i_dmemAck; same timeout rule, cause 3.
  - On ack, LOAD -> WB.
  - On ack, STORE: o_pcWe=1, pcSel=0, o_retire=1, -> FETCH.
- WB (1 cycle): o_regWe=1 unless i_inst[11:7]==0. o_pcWe=1, o_retire=1, -> FETCH.
  - wbSel: OP/OP-IMM/AUIPC 0, LOAD 1, JAL/JALR 2, LUI 3.
  - pcSel: JAL 1, JALR 2, else 0.
- HALT: all enables/requests 0, o_trap=1, cause held. Only reset exits.
- Timeout counter clears on every state entry and on ack.
- Ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES: ack wins.
- Acks outside FETCH/MEM are ignored.
- Zero-wait latencies (cycles): ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3, FENCE 2.
- Reset mid-MEM: request drops asynchronously, no write or retire occurs, FSM restarts at FETCH.

Test Plan:
- ADDI x1,x0,5 (0x00500093), imemAck after 2 wait cycles -> immType=0, srcB=1; regWe and pcWe (pcSel 0) in cycle 6; one retire pulse.
- LW x2,4(x1) (0x0040A103), dmemAck 3 cycles after MEM entry -> dmemReq held 4 cycles, dmemWe=0, WB with wbSel=1, regWe=1.
- BEQ x0,x0,8 (0x00000463) with brTaken=1 -> immType=2, pcWe=1, pcSel=1 in EXEC; no regWe; with brTaken=0 -> pcSel=0.
- 0xFFFFFFFF fetched -> HALT, o_trap=1, cause=1; further acks cause no enables until reset.
- TIMEOUT_CYCLES=4, imemAck never asserted -> HALT after 4 cycles, cause=2. Repeat with ack in the 4th cycle -> normal DECODE.
- SW during MEM, i_rstn pulsed low for 1 cycle -> dmemReq=0 immediately, no retire, FETCH with imemReq=1 after release; ADD x0,x1,x2 -> regWe stays 0.
